// File: rtl/bcd_pkg.sv
// Shared BCD constants and the per-decade validity helper.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, steps up/down when enabled with carry-in, flags its carry/borrow.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             ci,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic [BCD_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_val;
        end else if (en && ci) begin
            if (up_dn) begin
                q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    // co is carry when counting up and borrow when counting down.
    assign co = up_dn ? (q_q == BCD_MAX) : (q_q == BCD_MIN);
    assign q  = q_q;

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-decade cascaded BCD up/down counter with validated load and wrap/saturate limits.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [BCD_W*DIGITS-1:0]   count,
    output logic                      carry_out,
    output logic                      done,
    output logic                      load_err
);

    logic [DIGITS-1:0]       co_vec, ci_vec;
    logic [BCD_W*DIGITS-1:0] term_vec;
    logic                    load_ok, load_acc, all_term, near_term, step_en, acc;
    logic                    carry_q, carry_d, done_q, done_d, load_err_q, load_err_d;

    always_comb begin
        load_ok  = 1'b1;
        term_vec = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_ok = load_ok & is_bcd(load_val[BCD_W*k +: BCD_W]);
            term_vec[BCD_W*k +: BCD_W] = up_dn ? BCD_MAX : BCD_MIN;
        end
        load_acc = load && load_ok;
        all_term = &co_vec;
        // Next step lands on the terminal value: digit 0 one away, all others already there.
        near_term = (count[BCD_W-1:0] == (up_dn ? 4'd8 : 4'd1));
        for (int k = 1; k < DIGITS; k++) begin
            near_term = near_term & co_vec[k];
        end
        step_en = !load && enable && (WRAP || !all_term);
        acc = step_en;
        for (int k = 0; k < DIGITS; k++) begin
            ci_vec[k] = acc;
            acc       = acc & co_vec[k];
        end
    end

    always_comb begin
        carry_d    = 1'b0;
        load_err_d = load && !load_ok;
        done_d     = done_q;
        if (WRAP) begin
            carry_d = !load && enable && all_term;
            done_d  = carry_d;
        end else if (load_acc) begin
            done_d = (load_val == term_vec);
        end else if (load) begin
            done_d = all_term;
        end else if (enable) begin
            done_d = all_term || near_term;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .en     (step_en),
            .up_dn  (up_dn),
            .ld     (load_acc),
            .ld_val (load_val[BCD_W*k +: BCD_W]),
            .ci     (ci_vec[k]),
            .q      (count[BCD_W*k +: BCD_W]),
            .co     (co_vec[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q    <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign carry_out = carry_q;
    assign done      = done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Drives a wrapping and a saturating 3-digit counter with the same stimulus against an integer model.
module tb_bcd_updown_counter_n;

    localparam int ND   = 3;
    localparam int W    = 4 * ND;
    localparam int MAXV = 999;

    logic         clk = 1'b0;
    logic         reset, enable, up_dn, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count_w, count_s;
    logic         carry_w, carry_s, done_w, done_s, lerr_w, lerr_s;

    int checks = 0;
    int errors = 0;

    int m_val   [2];
    bit m_carry [2];
    bit m_done  [2];
    bit m_lerr  [2];
    int m_term;
    bit m_wrap;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.DIGITS(ND), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_w), .carry_out(carry_w), .done(done_w),
        .load_err(lerr_w)
    );

    bcd_updown_counter_n #(.DIGITS(ND), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_s), .carry_out(carry_s), .done(done_s),
        .load_err(lerr_s)
    );

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        t = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] x);
        for (int k = 0; k < ND; k++) if (x[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] x);
        int v = 0;
        for (int k = ND - 1; k >= 0; k--) v = v * 10 + int'(x[4*k +: 4]);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Integer model: index 0 wraps, index 1 saturates.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_val[i] = 0; m_carry[i] = 0; m_done[i] = 0; m_lerr[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_wrap     = (i == 0);
                m_term     = up_dn ? MAXV : 0;
                m_carry[i] = 0;
                m_lerr[i]  = 0;
                if (load) begin
                    if (bcd_ok(load_val)) m_val[i] = from_bcd(load_val);
                    else m_lerr[i] = 1;
                    m_done[i] = m_wrap ? 1'b0 : (m_val[i] == m_term);
                end else if (enable) begin
                    if (m_val[i] == m_term) begin
                        m_done[i] = 1;
                        if (m_wrap) begin
                            m_val[i]   = up_dn ? 0 : MAXV;
                            m_carry[i] = 1;
                        end
                    end else begin
                        m_val[i]  = up_dn ? m_val[i] + 1 : m_val[i] - 1;
                        m_done[i] = m_wrap ? 1'b0 : (m_val[i] == m_term);
                    end
                end else if (m_wrap) begin
                    m_done[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("w count", 32'(count_w), 32'(to_bcd(m_val[0])));
        check("w carry", 32'(carry_w), 32'(m_carry[0]));
        check("w done",  32'(done_w),  32'(m_done[0]));
        check("w lerr",  32'(lerr_w),  32'(m_lerr[0]));
        check("s count", 32'(count_s), 32'(to_bcd(m_val[1])));
        check("s carry", 32'(carry_s), 32'(m_carry[1]));
        check("s done",  32'(done_s),  32'(m_done[1]));
        check("s lerr",  32'(lerr_s),  32'(m_lerr[1]));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sat_cnt [5];
    bit           sat_dn  [5];

    initial begin
        sat_cnt = '{12'h998, 12'h999, 12'h999, 12'h999, 12'h999};
        sat_dn  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        reset = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        tick(2);
        check("reset count", 32'(count_w), 32'h000);
        check("reset flags", 32'({carry_w, done_w, lerr_w}), 32'h0);
        reset = 1'b1;

        enable = 1'b1;
        tick(115);
        check("count 115", 32'(count_w), 32'h115);
        check("done after 115", 32'(done_w), 32'h0);

        enable = 1'b0; load = 1'b1; load_val = 12'h998;
        tick(1);
        load = 1'b0; enable = 1'b1;
        tick(1);
        check("up 999", 32'({count_w, carry_w}), {19'h0, 12'h999, 1'b0});
        tick(1);
        check("up wrap", 32'({count_w, carry_w, done_w}), {18'h0, 12'h000, 2'b11});
        enable = 1'b0;
        tick(1);
        check("wrap pulse end", 32'({carry_w, done_w}), 32'h0);

        load = 1'b1; load_val = 12'h100;
        tick(1);
        load = 1'b0; up_dn = 1'b0; enable = 1'b1;
        tick(1);
        check("borrow 099", 32'(count_w), 32'h099);
        load = 1'b1; load_val = 12'h000;
        tick(1);
        check("load beats enable", 32'(count_w), 32'h000);
        load = 1'b0;
        tick(1);
        check("down wrap", 32'({count_w, carry_w, done_w}), {18'h0, 12'h999, 2'b11});

        enable = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 12'h997;
        tick(1);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("sat count", 32'(count_s), 32'(sat_cnt[i]));
            check("sat done", 32'({carry_s, done_s}), 32'({1'b0, sat_dn[i]}));
        end
        up_dn = 1'b0;
        tick(1);
        check("sat leave", 32'({count_s, done_s}), {19'h0, 12'h998, 1'b0});

        enable = 1'b0; load = 1'b1; load_val = 12'h1A5;
        tick(1);
        check("bad load count", 32'(count_s), 32'h998);
        check("bad load err", 32'(lerr_s), 32'h1);
        load = 1'b0;
        tick(1);
        check("bad load err end", 32'(lerr_s), 32'h0);
        load = 1'b1; load_val = 12'h456; enable = 1'b1; up_dn = 1'b1;
        tick(1);
        check("load with enable", 32'(count_w), 32'h456);
        load = 1'b0;
        tick(1);
        check("step after load", 32'(count_s), 32'h457);

        load = 1'b1; load_val = 12'h042; enable = 1'b0;
        tick(1);
        load = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async rst count", 32'({count_w, count_s}), 32'h0);
        check("async rst flags", 32'({carry_w, done_w, lerr_w, carry_s, done_s, lerr_s}), 32'h0);
        tick(1);
        reset = 1'b1; enable = 1'b1; up_dn = 1'b1;
        tick(1);
        check("first step", 32'(count_w), 32'h001);
        enable = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
Parametrised N-digit cascaded BCD counter. It generalises the fixed three-digit ones/tens/hundreds counter with:
- a configurable digit count
- up/down direction
- synchronous parallel load with BCD validity checking
- selectable wrap or saturate mode at the range limits

It sits beside the existing basic counting blocks and drives display/timer logic with a packed BCD bus.

Parameters:
DIGITS, 3, number of BCD decades (1..8); digit 0 is least significant.
WRAP, 1, 1 = roll over at the range limits; 0 = saturate and hold at the limit.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset; 0 clears all state
enable  in  1  count-step qualifier, sampled on the rising edge of clk
up_dn  in  1  1 = count up, 0 = count down
load  in  1  synchronous parallel load request
load_val  in  4*DIGITS  packed BCD load value; digit k at [4k+3:4k]
count  out  4*DIGITS  packed BCD count; digit k at [4k+3:4k]
carry_out  out  1  one-cycle pulse on wrap (up: 9..9->0..0, down: 0..0->9..9)
done  out  1  terminal indicator (see Behaviour)
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset=0, asynchronous): count=0, carry_out=0, done=0, load_err=0. Release is synchronous to clk; first step can occur on the first rising edge with reset=1.
- All outputs are registered. Count updates 1 cycle after the qualifying edge. No combinational path from inputs to outputs.
- Priority per edge: load > enable > hold.
- Load, valid (load=1, every digit of load_val <= 9):
  - count <= load_val, regardless of enable/up_dn
  - carry_out=0, load_err=0
- Load, invalid (load=1, any digit > 9):
  - count is unchanged and no step occurs that cycle
  - load_err=1 for exactly one cycle
- Step (load=0, enable=1):
  - up: digit 0 increments. A digit at 9 becomes 0 and propagates a carry to the next digit. A digit only changes when all lower digits produce a carry (ripple/cascade semantics, evaluated within one cycle).
  - down: digit 0 decrements. A digit at 0 becomes 9 and propagates a borrow.
- Hold (load=0, enable=0): count, done unchanged; carry_out=0; load_err=0.
- Terminal value: all-9s when up_dn=1, all-0s when up_dn=0.
- Range limit, WRAP=1:
  - a step from the terminal value wraps (up to all-0s, down to all-9s)
  - carry_out=1 and done=1 for that one cycle only
  - both are 0 otherwise
- Range limit, WRAP=0:
  - a step from the terminal value leaves count unchanged; carry_out stays 0
  - done is a registered level: 1 whenever the updated count equals the terminal value for the current up_dn, else 0
  - reversing up_dn at the limit makes the next enabled step leave the limit and clears done
- Simultaneous load + enable: load wins; no step, no carry.
- up_dn may change on any cycle; it takes effect on the next qualifying edge.
- Reset asserted mid-count or mid-load: all state clears immediately; the pending operation is discarded.
- Arithmetic is pure BCD per decade. Internal digit values never exceed 9; no binary-to-BCD conversion.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - function is_bcd(digit) for validity checks
- One sub-module, bcd_digit: a single decade with inputs clk, reset, en, up_dn, ld, ld_val, ci. It outputs q and co, where co means carry when up and borrow when down.
- Top level:
  - generate loop of DIGITS instances, with ci of digit k = AND of co from digits 0..k-1 gated by enable
  - load validation
  - wrap/saturate control, which suppresses the step at the limit when WRAP=0
  - carry_out/done/load_err registers

Test Plan:
- Reset then count, DIGITS=3, WRAP=1: reset low 2 cycles, then enable=1, up_dn=1 for 115 edges -> count=0x115, carry_out never high, done=0.
- Up wrap, WRAP=1: load 0x998, enable 2 edges -> count 0x999 then 0x000; carry_out=1 and done=1 only in the cycle count becomes 0x000.
- Down borrow/wrap, WRAP=1: load 0x100, up_dn=0, 1 edge -> 0x099. Load 0x000, 1 edge -> 0x999 with a carry_out pulse.
- Saturate, WRAP=0: load 0x997, up 5 edges -> 0x998, 0x999, 0x999, 0x999, 0x999; done=1 from the 0x999 cycle onward, carry_out=0. Then up_dn=0, 1 edge -> 0x998, done=0.
- Load rules: load 0x1A5 -> count unchanged, load_err one-cycle pulse. Load 0x456 with enable=1 -> count=0x456, no step that cycle.
- Async reset mid-count: assert reset between clock edges at count 0x042 -> count=0x000 and all flags 0 immediately, before the next edge. After release, first enabled up edge -> 0x001.
